// File: rtl/fib_sequencer.sv
// Fibonacci fill sequencer: drives an external regfile + ALU so that r0/r1 get seeds
// and each r[k] = r[k-2] + r[k-1], stopping early on ALU carry.
module fib_sequencer #(
  parameter int unsigned LAST_REG = 15,
  parameter logic [3:0]  ADD_OP   = 4'b0101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] seed0,
  input  logic [15:0] seed1,
  input  logic        aluCarry,
  output logic [15:0] regEnable,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  opcode,
  output logic        selImm,
  output logic [15:0] immediate,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [3:0] LastK = 4'(LAST_REG);

  typedef enum logic [2:0] {StIdle, StInit0, StInit1, StAdd, StDone} state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic        ovf_q, ovf_d;

  logic [15:0] en_d;
  logic [3:0]  srca_d, srcb_d, op_d;
  logic        sel_d;
  logic [15:0] imm_d;
  logic        busy_d, done_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        k_d = 4'd0;
        if (start) begin
          state_d = StInit0;
          ovf_d   = 1'b0;
        end
      end
      StInit0: state_d = StInit1;
      StInit1: begin
        state_d = StAdd;
        k_d     = 4'd2;
      end
      StAdd: begin
        if (aluCarry) ovf_d = 1'b1;
        if (aluCarry || k_q == LastK) state_d = StDone;
        else k_d = k_q + 4'd1;
      end
      StDone: begin
        state_d = StIdle;
        k_d     = 4'd0;
      end
      default: begin
        state_d = StIdle;
        k_d     = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state/k and registered, so they are pure flop
  // outputs (no input-to-output path) that still line up with the state they describe.
  always_comb begin
    en_d   = '0;
    srca_d = '0;
    srcb_d = '0;
    op_d   = '0;
    sel_d  = 1'b0;
    imm_d  = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      StInit0: begin
        en_d   = 16'h0001;
        sel_d  = 1'b1;
        imm_d  = seed0;
        busy_d = 1'b1;
      end
      StInit1: begin
        en_d   = 16'h0002;
        sel_d  = 1'b1;
        imm_d  = seed1;
        busy_d = 1'b1;
      end
      StAdd: begin
        en_d   = 16'h0001 << k_d;
        srca_d = k_d - 4'd2;
        srcb_d = k_d - 4'd1;
        op_d   = ADD_OP;
        busy_d = 1'b1;
      end
      StDone: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      k_q       <= '0;
      ovf_q     <= 1'b0;
      regEnable <= '0;
      srcA      <= '0;
      srcB      <= '0;
      opcode    <= '0;
      selImm    <= 1'b0;
      immediate <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ovf_q     <= ovf_d;
      regEnable <= en_d;
      srcA      <= srca_d;
      srcB      <= srcb_d;
      opcode    <= op_d;
      selImm    <= sel_d;
      immediate <= imm_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer: attached regfile + ALU, directed table, corner sequences and
// random seeds checked against a plain-arithmetic Fibonacci model.
module tb_fib_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, start3;
  logic [15:0] seed0, seed1;
  logic        aluCarry, use_alu, carry_ovr, clear_rf;
  logic [15:0] regEnable, immediate;
  logic [3:0]  srcA, srcB, opcode;
  logic        selImm, busy, done, overflow;

  logic        aluCarry3;
  logic [15:0] regEnable3, immediate3;
  logic [3:0]  srcA3, srcB3, opcode3;
  logic        selImm3, busy3, done3, overflow3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  fib_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .seed0(seed0), .seed1(seed1),
    .aluCarry(aluCarry), .regEnable(regEnable), .srcA(srcA), .srcB(srcB),
    .opcode(opcode), .selImm(selImm), .immediate(immediate), .busy(busy),
    .done(done), .overflow(overflow)
  );

  fib_sequencer #(.LAST_REG(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .seed0(seed0), .seed1(seed1),
    .aluCarry(aluCarry3), .regEnable(regEnable3), .srcA(srcA3), .srcB(srcB3),
    .opcode(opcode3), .selImm(selImm3), .immediate(immediate3), .busy(busy3),
    .done(done3), .overflow(overflow3)
  );

  // Regfile + adder environment for each instance.
  logic [15:0] rf [16];
  logic [15:0] rf3 [16];
  logic [16:0] sum, sum3;
  assign sum       = {1'b0, rf[srcA]} + {1'b0, rf[srcB]};
  assign sum3      = {1'b0, rf3[srcA3]} + {1'b0, rf3[srcB3]};
  assign aluCarry  = use_alu ? sum[16] : carry_ovr;
  assign aluCarry3 = sum3[16];

  always @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (clear_rf) rf[i] <= 16'hDEAD;
      else if (regEnable[i]) rf[i] <= selImm ? immediate : sum[15:0];
      if (regEnable3[i]) rf3[i] <= selImm3 ? immediate3 : sum3[15:0];
    end
  end

  // Reference: what each register should hold, where the run stops, whether it overflowed.
  logic [15:0] exp_v [16];
  int          exp_stop;
  bit          exp_ovf;

  task automatic compute_model(input logic [15:0] a, input logic [15:0] b, input int last);
    for (int i = 0; i < 16; i++) exp_v[i] = 16'hDEAD;
    exp_v[0] = a;
    exp_v[1] = b;
    exp_ovf  = 1'b0;
    exp_stop = last;
    for (int k = 2; k <= last; k++) begin
      int s;
      s = int'(exp_v[k-2]) + int'(exp_v[k-1]);
      exp_v[k] = 16'(s);
      if (s > 65535) begin
        exp_ovf  = 1'b1;
        exp_stop = k;
        break;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got !== want) $display("FAIL %s: got %h expected %h", name, got, want);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check(name, 64'(seen), 64'd1);
    tick();
  endtask

  // Full run on the default instance; leaves the bench in the IDLE cycle after DONE.
  task automatic run_main(input logic [15:0] a, input logic [15:0] b, input bit hold);
    logic [17:0] exp;
    compute_model(a, b, 15);
    clear_rf = 1'b1;
    tick();
    clear_rf = 1'b0;
    seed0 = a;
    seed1 = b;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int c = 1; c <= exp_stop + 2; c++) begin
      if (c <= exp_stop + 1) exp = {16'h0001 << (c - 1), 1'b1, 1'b0};
      else exp = {16'h0000, 1'b1, 1'b1};
      check("trace", 64'({regEnable, busy, done}), 64'(exp));
      tick();
    end
    check("idle_after", 64'({busy, done}), 64'd0);
    check("overflow", 64'(overflow), 64'(exp_ovf));
    for (int i = 0; i < 16; i++) check("regfile", 64'(rf[i]), 64'(exp_v[i]));
  endtask

  typedef struct {
    logic [15:0] s0;
    logic [15:0] s1;
    int          last_k;
    bit          ovf;
    logic [15:0] rlast;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'd0,     16'd1,     15, 1'b0, 16'd610};
    vecs[1] = '{16'd40000, 16'd30000, 2,  1'b1, 16'd4464};
    vecs[2] = '{16'd1,     16'd1,     15, 1'b0, 16'd987};
    vecs[3] = '{16'd0,     16'd0,     15, 1'b0, 16'd0};
    vecs[4] = '{16'd65535, 16'd1,     2,  1'b1, 16'd0};
    vecs[5] = '{16'd0,     16'd65535, 3,  1'b1, 16'd65534};

    use_alu   = 1'b1;
    carry_ovr = 1'b0;
    clear_rf  = 1'b0;
    start3    = 1'b0;
    seed0     = 16'h1234;
    seed1     = 16'h5678;

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    check("reset_outputs",
          {regEnable, srcA, srcB, opcode, selImm, immediate, busy, done, overflow}, 64'd0);
    check("reset_outputs3", 64'({regEnable3, busy3, done3, overflow3}), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("idle_no_write", 64'({regEnable, busy}), 64'd0);

    // Directed table; vecs[0] also covers r10=55.
    foreach (vecs[i]) begin
      run_main(vecs[i].s0, vecs[i].s1, 1'b0);
      check("tbl_stop", 64'(exp_stop), 64'(vecs[i].last_k));
      check("tbl_ovf", 64'(overflow), 64'(vecs[i].ovf));
      check("tbl_rlast", 64'(rf[vecs[i].last_k]), 64'(vecs[i].rlast));
      if (i == 0) check("tbl_r10", 64'(rf[10]), 64'd55);
    end

    // Reset mid-sequence at k=6, then replay.
    seed0 = 16'd0;
    seed1 = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (regEnable == 16'h0040) break;
      tick();
    end
    check("mid_reach_k6", 64'(regEnable), 64'h0040);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_reset_outputs",
          {regEnable, srcA, srcB, opcode, selImm, immediate, busy, done, overflow}, 64'd0);
    tick();
    check("mid_reset_idle", 64'({regEnable, busy}), 64'd0);
    run_main(16'd0, 16'd1, 1'b0);

    // Start held for the whole run: one done, then a fresh run from IDLE.
    run_main(16'd0, 16'd1, 1'b1);
    tick();
    check("hold_restart", 64'({regEnable, busy, done}), {46'd0, 16'h0001, 1'b1, 1'b0});
    start = 1'b0;
    wait_done("hold_second_done");

    // Carry in IDLE/INIT is ignored; carry in ADD at k=5 ends the run.
    use_alu   = 1'b0;
    carry_ovr = 1'b1;
    tick();
    tick();
    check("carry_idle_ovf", 64'(overflow), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("carry_init0", 64'({regEnable, overflow}), {47'd0, 16'h0001, 1'b0});
    tick();
    check("carry_init1", 64'({regEnable, overflow}), {47'd0, 16'h0002, 1'b0});
    tick();
    carry_ovr = 1'b0;
    check("carry_add_k2", 64'({regEnable, overflow}), {47'd0, 16'h0004, 1'b0});
    tick();
    tick();
    tick();
    check("carry_add_k5", 64'(regEnable), 64'h0020);
    carry_ovr = 1'b1;
    tick();
    check("carry_done", 64'({regEnable, done, busy, overflow}), {45'd0, 16'h0000, 3'b111});
    tick();
    tick();
    check("carry_sticky", 64'({busy, overflow}), 64'b01);
    carry_ovr = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ovf_cleared", 64'({regEnable, overflow}), {47'd0, 16'h0001, 1'b0});
    wait_done("carry_run_done");
    use_alu = 1'b1;

    // LAST_REG=3 instance.
    compute_model(16'd0, 16'd1, 3);
    seed0  = 16'd0;
    seed1  = 16'd1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      logic [17:0] exp3;
      if (c <= 4) exp3 = {16'h0001 << (c - 1), 1'b1, 1'b0};
      else exp3 = {16'h0000, 1'b1, 1'b1};
      check("p3_trace", 64'({regEnable3, busy3, done3}), 64'(exp3));
      tick();
    end
    check("p3_idle", 64'({busy3, overflow3}), 64'd0);
    for (int i = 0; i <= 3; i++) check("p3_regfile", 64'(rf3[i]), 64'(exp_v[i]));
    check("p3_r3", 64'(rf3[3]), 64'd2);

    // Random seeds: small ones run to r15, wide ones usually overflow early.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      if (i % 2 == 0) begin
        a = 16'($urandom_range(0, 7));
        b = 16'($urandom_range(0, 7));
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      run_main(a, b, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fib_sequencer.md
FIB_SEQUENCER -- requirements
Module: fib_sequencer

Interface
- REQ-001 The module SHALL have parameter LAST_REG, default 15, meaning the index of the last register written; legal range 2..15.
- REQ-002 The module SHALL have parameter ADD_OP, default 4'b0101, meaning the ALU opcode driven during add steps.
- REQ-003 Port clk  input  1: the single clock; all state changes on the rising edge.
- REQ-004 Port reset  input  1: the reset, synchronous and active-high.
- REQ-005 Port start  input  1: request to run one sequence; sampled only in IDLE.
- REQ-006 Port seed0  input  16: value written to r0.
- REQ-007 Port seed1  input  16: value written to r1.
- REQ-008 Port aluCarry  input  1: ALU carry-out for the current srcA+srcB operation.
- REQ-009 Port regEnable  output  16: one-hot regfile write enable.
- REQ-010 Port srcA  output  4: regfile read select for ALU operand A.
- REQ-011 Port srcB  output  4: regfile read select for ALU operand B.
- REQ-012 Port opcode  output  4: ALU opcode.
- REQ-013 Port selImm  output  1: write-data mux select; 1 = immediate, 0 = ALU result.
- REQ-014 Port immediate  output  16: write data when selImm=1.
- REQ-015 Port busy  output  1: high in every state except IDLE.
- REQ-016 Port done  output  1: one-cycle completion pulse.
- REQ-017 Port overflow  output  1: sticky carry flag for the last run.

Function
- REQ-018 The FSM SHALL have states IDLE, INIT0, INIT1, ADD and DONE, plus a 4-bit step counter k.
- REQ-019 Outputs SHALL be Moore outputs, decoded from the state register and k only, with no combinational path from inputs.
- REQ-020 IDLE: when start=1, the FSM SHALL go to INIT0 and clear overflow; otherwise it SHALL stay in IDLE. All outputs are 0 except overflow.
- REQ-021 INIT0 SHALL drive regEnable=16'h0001, selImm=1 and immediate=seed0, then go to INIT1.
- REQ-022 INIT1 SHALL drive regEnable=16'h0002, selImm=1 and immediate=seed1, then go to ADD with k=2.
- REQ-023 ADD SHALL drive regEnable=1<<k, srcA=k-2, srcB=k-1, opcode=ADD_OP, selImm=0 and immediate=0.
- REQ-024 In ADD, the FSM SHALL go to DONE when aluCarry=1 or k==LAST_REG; otherwise it SHALL increment k.
- REQ-025 When aluCarry=1 in ADD, the FSM SHALL set overflow=1; the write of r[k] in that cycle still occurs.
- REQ-026 DONE SHALL drive done=1 and busy=1 for exactly one cycle, then go to IDLE.
- REQ-027 overflow SHALL hold its value until the next accepted start or reset.
- REQ-028 start asserted while busy=1 SHALL be ignored, with no queuing.
- REQ-029 Latency: with start sampled at edge 0 and no carry, done SHALL be high in cycle LAST_REG+2 (cycle 17 for the default).
- REQ-030 k SHALL never exceed LAST_REG, and regEnable SHALL never have more than one bit set.
- REQ-031 aluCarry SHALL be ignored in every state other than ADD.

Reset
- REQ-032 reset=1 at a clock edge SHALL force state=IDLE, k=0, regEnable=0, srcA=0, srcB=0, opcode=0, selImm=0, immediate=0, busy=0, done=0 and overflow=0.
- REQ-033 reset SHALL take priority over start and over any in-progress state, including a mid-sequence ADD.
- REQ-034 No regfile write enable SHALL be asserted in the cycle after a reset edge.

Verification
- REQ-035 Nominal run: seed0=0, seed1=1, start pulse -> regEnable steps 0001, 0002, 0004 ... 8000 in cycles 1..16, done in cycle 17, overflow=0. With regfile+ALU attached, r15=610 and r10=55.
- REQ-036 Overflow: seed0=16'd40000, seed1=16'd30000, aluCarry driven by a real ALU -> carry at k=2, r2 written, done in the next cycle, overflow=1, and r3..r15 enables never asserted.
- REQ-037 Reset mid-sequence: reset asserted while k=6 -> the next cycle has all outputs 0 and state IDLE; a fresh start then replays from INIT0.
- REQ-038 Start while busy: start held high for the whole run -> exactly one sequence and one done pulse, then a new run begins from IDLE on the following cycle.
- REQ-039 Parameter: LAST_REG=3 with seeds 0 and 1 -> enables 0001, 0002, 0004, 0008, then done in cycle 5, and r3=2.
- REQ-040 Flag hygiene: aluCarry held at 1 during IDLE and INIT states -> overflow stays 0 unless carry is present during an ADD cycle.
